// File: rtl/control_sequencer_if.sv
// Handshake/bus bundle between the microcoded control sequencer and its host.
// The step_req signal exists only when SEQ_SINGLE_STEP_EN is defined.
interface control_sequencer_if #(
    parameter int unsigned CW_WIDTH     = 32,
    parameter int unsigned OPCODE_WIDTH = 8,
    parameter int unsigned FLAG_BITS    = 4,
    parameter int unsigned STEP_BITS    = 3
) ();
    localparam int unsigned ADDR_W  = OPCODE_WIDTH + FLAG_BITS + STEP_BITS;
    localparam int unsigned ENTRY_W = CW_WIDTH + 2;

    logic                    run;
    logic [OPCODE_WIDTH-1:0] opcode_in;
    logic [FLAG_BITS-1:0]    flags_in;
    logic                    ucode_we;
    logic [ADDR_W-1:0]       ucode_addr;
    logic [ENTRY_W-1:0]      ucode_wdata;
`ifdef SEQ_SINGLE_STEP_EN
    logic                    step_req;
`endif
    logic [CW_WIDTH-1:0]     control_word;
    logic                    ctrlen;
    logic                    halted;
    logic [STEP_BITS-1:0]    step;

    modport master (
        output run, opcode_in, flags_in, ucode_we, ucode_addr, ucode_wdata,
`ifdef SEQ_SINGLE_STEP_EN
        output step_req,
`endif
        input  control_word, ctrlen, halted, step
    );

    modport slave (
        input  run, opcode_in, flags_in, ucode_we, ucode_addr, ucode_wdata,
`ifdef SEQ_SINGLE_STEP_EN
        input  step_req,
`endif
        output control_word, ctrlen, halted, step
    );
endinterface

// File: rtl/control_sequencer.sv
// Microcoded control unit: fetch, latch opcode, step through {opcode,flags,step}
// microcode RAM, then refetch, idle or halt. Optional: SEQ_SINGLE_STEP_EN.
module control_sequencer #(
    parameter int unsigned          CW_WIDTH     = 32,
    parameter int unsigned          OPCODE_WIDTH = 8,
    parameter int unsigned          FLAG_BITS    = 4,
    parameter int unsigned          STEP_BITS    = 3,
    parameter logic [CW_WIDTH-1:0]  IDLE_CW      = 32'h07FF58F0,
    parameter logic [CW_WIDTH-1:0]  FETCH_CW     = 32'h07FF58F9
) (
    input  logic                 clk,
    input  logic                 rst,
    control_sequencer_if.slave   bus
);
    localparam int unsigned ADDR_W = OPCODE_WIDTH + FLAG_BITS + STEP_BITS;
    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam logic [STEP_BITS-1:0] STEP_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_HALT
    } state_t;

    typedef struct packed {
        logic                halt;
        logic                last;
        logic [CW_WIDTH-1:0] cw;
    } ucode_entry_t;

    state_t                  state;
    logic [OPCODE_WIDTH-1:0] opcode_q;
    logic [STEP_BITS-1:0]    step_q;
    logic [CW_WIDTH-1:0]     cw_q;
    logic                    ctrlen_q;
    logic                    halted_q;

    ucode_entry_t            ucode_ram [DEPTH];

    logic                    advance;
    logic [STEP_BITS-1:0]    step_next;
    logic [ADDR_W-1:0]       fetch_addr;
    logic [ADDR_W-1:0]       cur_addr;
    logic [ADDR_W-1:0]       next_addr;
    ucode_entry_t            fetch_entry;
    ucode_entry_t            cur_entry;
    ucode_entry_t            next_entry;

`ifdef SEQ_SINGLE_STEP_EN
    assign advance = bus.step_req;
`else
    assign advance = 1'b1;
`endif

    // Flags are sampled live every microstep, so all three lookups are combinational.
    assign step_next   = step_q + 1'b1;
    assign fetch_addr  = {bus.opcode_in, bus.flags_in, {STEP_BITS{1'b0}}};
    assign cur_addr    = {opcode_q, bus.flags_in, step_q};
    assign next_addr   = {opcode_q, bus.flags_in, step_next};
    assign fetch_entry = ucode_ram[fetch_addr];
    assign cur_entry   = ucode_ram[cur_addr];
    assign next_entry  = ucode_ram[next_addr];

    // NOTE: the microcode store has no reset branch -- its contents survive rst and
    // keeping it reset-free lets synthesis map it onto a RAM macro.
    always_ff @(posedge clk) begin
        if (bus.ucode_we && state == S_IDLE) begin
            ucode_ram[bus.ucode_addr] <= ucode_entry_t'(bus.ucode_wdata);
        end
    end

    // NOTE: all sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            opcode_q <= '0;
            step_q   <= '0;
            cw_q     <= IDLE_CW;
            ctrlen_q <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (advance && bus.run) begin
                        state    <= S_FETCH;
                        cw_q     <= FETCH_CW;
                        ctrlen_q <= 1'b1;
                        step_q   <= '0;
                    end
                end

                S_FETCH: begin
                    if (advance) begin
                        state    <= S_EXEC;
                        opcode_q <= bus.opcode_in;
                        step_q   <= '0;
                        cw_q     <= fetch_entry.cw;
                    end
                end

                S_EXEC: begin
                    if (advance) begin
                        if (cur_entry.halt) begin
                            state    <= S_HALT;
                            cw_q     <= IDLE_CW;
                            ctrlen_q <= 1'b0;
                            halted_q <= 1'b1;
                            step_q   <= '0;
                        end else if (cur_entry.last || step_q == STEP_MAX) begin
                            // The last step always ends the instruction; run only
                            // chooses between refetching and parking in IDLE.
                            step_q <= '0;
                            if (bus.run) begin
                                state <= S_FETCH;
                                cw_q  <= FETCH_CW;
                            end else begin
                                state    <= S_IDLE;
                                cw_q     <= IDLE_CW;
                                ctrlen_q <= 1'b0;
                            end
                        end else begin
                            step_q <= step_next;
                            cw_q   <= next_entry.cw;
                        end
                    end
                end

                S_HALT: begin
                    state <= S_HALT;
                end

                default: begin
                    state    <= S_IDLE;
                    cw_q     <= IDLE_CW;
                    ctrlen_q <= 1'b0;
                    halted_q <= 1'b0;
                    step_q   <= '0;
                end
            endcase
        end
    end

    assign bus.control_word = cw_q;
    assign bus.ctrlen       = ctrlen_q;
    assign bus.halted       = halted_q;
    assign bus.step         = step_q;
endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: directed microprograms push expected
// outputs per clock; an independent monitor pops and compares on each negedge.
module tb_control_sequencer;
    localparam logic [31:0] IDLE_CW  = 32'h07FF58F0;
    localparam logic [31:0] FETCH_CW = 32'h07FF58F9;

    typedef struct packed {
        logic [31:0] cw;
        logic        en;
        logic        halted;
        logic [2:0]  step;
        logic [7:0]  tag;
    } exp_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    exp_t exp_q[$];

    control_sequencer_if bus ();

    control_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input int tag, input string what,
                         input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL t%0d %s: got %0h want %0h", tag, what, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check(int'(e.tag), "control_word", 64'(bus.control_word), 64'(e.cw));
            check(int'(e.tag), "ctrlen",       64'(bus.ctrlen),       64'(e.en));
            check(int'(e.tag), "halted",       64'(bus.halted),       64'(e.halted));
            check(int'(e.tag), "step",         64'(bus.step),         64'(e.step));
        end
    end

    task automatic expect_now(input logic [31:0] cw, input logic en, input logic h,
                              input logic [2:0] st, input logic [7:0] tag);
        exp_q.push_back('{cw: cw, en: en, halted: h, step: st, tag: tag});
    endtask

    // One clock: outputs after this posedge must match the given values.
    task automatic tick(input logic [31:0] cw, input logic en, input logic h,
                        input logic [2:0] st, input logic [7:0] tag);
        @(posedge clk);
        #1;
        expect_now(cw, en, h, st, tag);
    endtask

    task automatic wr(input logic [7:0] op, input logic [3:0] f, input logic [2:0] s,
                      input logic h, input logic l, input logic [31:0] cw);
        bus.ucode_we    = 1'b1;
        bus.ucode_addr  = {op, f, s};
        bus.ucode_wdata = {h, l, cw};
        tick(IDLE_CW, 1'b0, 1'b0, 3'd0, 8'd0);
        bus.ucode_we    = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst             = 1'b0;
        bus.run         = 1'b0;
        bus.opcode_in   = '0;
        bus.flags_in    = '0;
        bus.ucode_we    = 1'b0;
        bus.ucode_addr  = '0;
        bus.ucode_wdata = '0;
`ifdef SEQ_SINGLE_STEP_EN
        bus.step_req    = 1'b1;
`endif
        #1;
        expect_now(IDLE_CW, 1'b0, 1'b0, 3'd0, 8'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick(IDLE_CW, 1'b0, 1'b0, 3'd0, 8'd0);

        // Microcode image
        wr(8'h01, 4'h0, 3'd0, 1'b0, 1'b0, 32'h07FF580F);
        wr(8'h01, 4'h0, 3'd1, 1'b0, 1'b1, 32'h07FF581F);
        wr(8'h02, 4'h0, 3'd0, 1'b0, 1'b1, 32'h07FF4405);
        wr(8'h02, 4'h2, 3'd0, 1'b0, 1'b1, 32'h07FF000A);
        for (int s = 0; s < 8; s++) begin
            wr(8'h03, 4'h0, 3'(s), 1'b0, 1'b0, 32'h03000000 + 32'(s));
        end
        for (int s = 0; s < 3; s++) begin
            wr(8'h04, 4'h0, 3'(s), 1'b0, (s == 2), 32'h04000000 + 32'(s));
        end
        wr(8'hFF, 4'h0, 3'd0, 1'b1, 1'b1, 32'h0FFFFFFF);

        // Two-step instruction, back to back, then stop at boundary
        bus.run = 1'b1; bus.opcode_in = 8'h01; bus.flags_in = 4'h0;
        tick(FETCH_CW,     1'b1, 1'b0, 3'd0, 8'd2);
        tick(32'h07FF580F, 1'b1, 1'b0, 3'd0, 8'd2);
        tick(32'h07FF581F, 1'b1, 1'b0, 3'd1, 8'd2);
        tick(FETCH_CW,     1'b1, 1'b0, 3'd0, 8'd2);
        tick(32'h07FF580F, 1'b1, 1'b0, 3'd0, 8'd2);
        bus.run = 1'b0;
        tick(32'h07FF581F, 1'b1, 1'b0, 3'd1, 8'd2);
        tick(IDLE_CW,      1'b0, 1'b0, 3'd0, 8'd2);

        // Flags select the microcode entry
        bus.run = 1'b1; bus.opcode_in = 8'h02;
        tick(FETCH_CW,     1'b1, 1'b0, 3'd0, 8'd3);
        tick(32'h07FF4405, 1'b1, 1'b0, 3'd0, 8'd3);
        tick(FETCH_CW,     1'b1, 1'b0, 3'd0, 8'd3);
        bus.flags_in = 4'b0010;
        tick(32'h07FF000A, 1'b1, 1'b0, 3'd0, 8'd3);
        bus.run = 1'b0;
        tick(IDLE_CW,      1'b0, 1'b0, 3'd0, 8'd3);
        bus.flags_in = 4'h0;

        // No last bit: max step forces the end of the instruction
        bus.run = 1'b1; bus.opcode_in = 8'h03;
        tick(FETCH_CW,     1'b1, 1'b0, 3'd0, 8'd5);
        tick(32'h03000000, 1'b1, 1'b0, 3'd0, 8'd5);
        bus.run = 1'b0;
        for (int s = 1; s < 8; s++) begin
            tick(32'h03000000 + 32'(s), 1'b1, 1'b0, 3'(s), 8'd5);
        end
        tick(IDLE_CW,      1'b0, 1'b0, 3'd0, 8'd5);

        // run dropped mid-instruction plus a write attempt during EXEC
        bus.run = 1'b1; bus.opcode_in = 8'h04;
        tick(FETCH_CW,     1'b1, 1'b0, 3'd0, 8'd6);
        tick(32'h04000000, 1'b1, 1'b0, 3'd0, 8'd6);
        tick(32'h04000001, 1'b1, 1'b0, 3'd1, 8'd6);
        bus.run         = 1'b0;
        bus.ucode_we    = 1'b1;
        bus.ucode_addr  = {8'h04, 4'h0, 3'd2};
        bus.ucode_wdata = {1'b0, 1'b1, 32'hDEADBEEF};
        tick(32'h04000002, 1'b1, 1'b0, 3'd2, 8'd6);
        bus.ucode_we = 1'b0;
        tick(IDLE_CW,      1'b0, 1'b0, 3'd0, 8'd6);
        bus.run = 1'b1;
        tick(FETCH_CW,     1'b1, 1'b0, 3'd0, 8'd6);
        tick(32'h04000000, 1'b1, 1'b0, 3'd0, 8'd6);
        tick(32'h04000001, 1'b1, 1'b0, 3'd1, 8'd6);
        bus.run = 1'b0;
        tick(32'h04000002, 1'b1, 1'b0, 3'd2, 8'd6);
        tick(IDLE_CW,      1'b0, 1'b0, 3'd0, 8'd6);

        // Write and run in the same IDLE cycle
        bus.ucode_we    = 1'b1;
        bus.ucode_addr  = {8'h05, 4'h0, 3'd0};
        bus.ucode_wdata = {1'b0, 1'b1, 32'h05050505};
        bus.run = 1'b1; bus.opcode_in = 8'h05;
        tick(FETCH_CW,     1'b1, 1'b0, 3'd0, 8'd7);
        bus.ucode_we = 1'b0;
        tick(32'h05050505, 1'b1, 1'b0, 3'd0, 8'd7);
        bus.run = 1'b0;
        tick(IDLE_CW,      1'b0, 1'b0, 3'd0, 8'd7);

        // Halt is sticky with run held high
        bus.run = 1'b1; bus.opcode_in = 8'hFF;
        tick(FETCH_CW,     1'b1, 1'b0, 3'd0, 8'd4);
        tick(32'h0FFFFFFF, 1'b1, 1'b0, 3'd0, 8'd4);
        tick(IDLE_CW,      1'b0, 1'b1, 3'd0, 8'd4);
        repeat (10) tick(IDLE_CW, 1'b0, 1'b1, 3'd0, 8'd4);
        @(negedge clk);
        #1 rst = 1'b0;
        #1 expect_now(IDLE_CW, 1'b0, 1'b0, 3'd0, 8'd4);
        @(negedge clk);
        #1;
        bus.run = 1'b0;
        rst = 1'b1;
        tick(IDLE_CW,      1'b0, 1'b0, 3'd0, 8'd4);

        // Asynchronous reset in the middle of EXEC
        bus.run = 1'b1; bus.opcode_in = 8'h01;
        tick(FETCH_CW,     1'b1, 1'b0, 3'd0, 8'd1);
        tick(32'h07FF580F, 1'b1, 1'b0, 3'd0, 8'd1);
        @(negedge clk);
        #1 rst = 1'b0;
        #1 expect_now(IDLE_CW, 1'b0, 1'b0, 3'd0, 8'd1);
        @(negedge clk);
        #1;
        bus.run = 1'b0;
        rst = 1'b1;
        tick(IDLE_CW,      1'b0, 1'b0, 3'd0, 8'd1);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
